// File: rtl/uart_tx_fifo_8n1.sv
// UART 8N1 transmitter fed by a small byte FIFO with a valid/ready write port.
// Serialises queued bytes LSB first; back-to-back frames leave no idle gap on the line.
module uart_tx_fifo_8n1 #(
   parameter int unsigned CLK_HZ     = 12000000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] txbyte,
   input  logic       senddata,
   output logic       ready,
   output logic       uarttx,
   output logic       txbusy,
   output logic       txdone
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state, state_next;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [BAUD_W-1:0] baud_cnt, baud_next;
   logic [2:0]        bit_idx, bit_next;
   logic [7:0]        shift, shift_next;
   logic              tx_next, done_next;
   logic              push, pop, bit_end;

   assign ready   = (count != CNT_W'(FIFO_DEPTH));
   assign push    = senddata && ready;
   assign txbusy  = (state != IDLE) || (count != '0);
   assign bit_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

   // Byte storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= txbyte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // tx_next is the level for the next cycle, so the line trails the state by one clock.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_idx;
      shift_next = shift;
      pop        = 1'b0;
      tx_next    = 1'b1;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            baud_next = '0;
            bit_next  = '0;
            if (count != '0) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr];
               state_next = START;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (bit_end) begin
               baud_next  = '0;
               bit_next   = '0;
               state_next = DATA;
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end
         DATA: begin
            tx_next = shift[0];
            if (bit_end) begin
               baud_next  = '0;
               shift_next = {1'b0, shift[7:1]};
               bit_next   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = STOP;
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end
         STOP: begin
            tx_next = 1'b1;
            if (bit_end) begin
               baud_next = '0;
               done_next = 1'b1;
               if (count != '0) begin
                  pop        = 1'b1;
                  shift_next = mem[rd_ptr];
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         uarttx   <= 1'b1;
         txdone   <= 1'b0;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_idx  <= bit_next;
         shift    <= shift_next;
         uarttx   <= tx_next;
         txdone   <= done_next;
      end
   end

endmodule
